// File: rtl/mop_pkg.sv
// Shared types for the multi-op pipelined processor: opcodes, engine states
// and the opcode field width.
package mop_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic {
    IDLE    = 1'b0,
    DIV_RUN = 1'b1
  } state_e;

endpackage

// File: rtl/mop_result_fifo.sv
// Show-ahead result FIFO holding {data, flag, op}; the head is visible
// combinationally and reads as zero while the FIFO is empty.
module mop_result_fifo
  import mop_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int OUT_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         push_flag,
  input  logic [OP_W-1:0]              push_op,
  input  logic                         pop,
  output logic [DATA_W-1:0]            head_data,
  output logic                         head_flag,
  output logic [OP_W-1:0]              head_op,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(OUT_DEPTH):0]   count
);

  localparam int PTR_W   = $clog2(OUT_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_W + 1 + OP_W;

  logic [ENTRY_W-1:0] mem [OUT_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               do_push, do_pop;
  logic [ENTRY_W-1:0] head;

  assign full    = (count_reg == CNT_W'(OUT_DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= {push_data, push_flag, push_op};
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head      = empty ? '0 : mem[rd_ptr_reg];
  assign head_data = head[ENTRY_W-1 -: DATA_W];
  assign head_flag = head[OP_W];
  assign head_op   = head[OP_W-1:0];

endmodule

// File: rtl/multi_op_pipe_processor.sv
// Single-issue ADD/SUB/MUL/DIV engine: one-cycle ALU ops, a restoring
// divider for DIV (quotient of a/(b+1)), results queued in an output FIFO.
module multi_op_pipe_processor
  import mop_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op_sel,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_flag,
  output logic [1:0]        out_op
);

  localparam int CNT_W  = $clog2(OUT_DEPTH) + 1;
  localparam int ITER_W = $clog2(DATA_W + 1);

  state_e              state_reg, state_next;
  logic [DATA_W-1:0]   quo_reg, quo_next;
  logic [DATA_W:0]     rem_reg, rem_next, divisor_reg, trial;
  logic [ITER_W-1:0]   iter_reg;

  op_e                 in_op;
  logic                accept, div_done;
  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   alu_data;
  logic                alu_flag;

  logic                push, fifo_empty, fifo_full;
  logic [DATA_W-1:0]   push_data;
  logic                push_flag;
  logic [OP_W-1:0]     push_op;
  logic [CNT_W-1:0]    fifo_count;

  assign in_op    = op_e'(op_sel);
  assign in_ready = !rst && (state_reg == IDLE) && (fifo_count < CNT_W'(OUT_DEPTH));
  assign accept   = in_valid && in_ready;
  assign div_done = (state_reg == DIV_RUN) && (iter_reg == ITER_W'(1));

  assign sum  = {1'b0, a_in} + {1'b0, b_in};
  assign prod = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};

  always_comb begin
    alu_data = sum[DATA_W-1:0];
    alu_flag = sum[DATA_W];
    case (in_op)
      OP_SUB: begin
        alu_data = a_in - b_in;
        alu_flag = (a_in < b_in);
      end
      OP_MUL: begin
        alu_data = prod[DATA_W-1:0];
        alu_flag = |prod[2*DATA_W-1:DATA_W];
      end
      default: ;
    endcase
  end

  // The remainder is always below the divisor (<= 2^W), so its top bit is
  // never set and can be dropped when shifting in the next dividend bit.
  always_comb begin
    trial    = {rem_reg[DATA_W-1:0], quo_reg[DATA_W-1]};
    rem_next = trial;
    quo_next = {quo_reg[DATA_W-2:0], 1'b0};
    if (trial >= divisor_reg) begin
      rem_next = trial - divisor_reg;
      quo_next = {quo_reg[DATA_W-2:0], 1'b1};
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && in_op == OP_DIV) state_next = DIV_RUN;
      DIV_RUN: if (div_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      quo_reg     <= '0;
      rem_reg     <= '0;
      divisor_reg <= '0;
      iter_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept && in_op == OP_DIV) begin
        quo_reg     <= a_in;
        rem_reg     <= '0;
        divisor_reg <= {1'b0, b_in} + (DATA_W+1)'(1);
        iter_reg    <= ITER_W'(DATA_W);
      end else if (state_reg == DIV_RUN) begin
        quo_reg  <= quo_next;
        rem_reg  <= rem_next;
        iter_reg <= iter_reg - ITER_W'(1);
      end
    end
  end

  // Issue is gated on a free slot, so a finishing DIV always finds room.
  assign push      = (accept && in_op != OP_DIV) || div_done;
  assign push_data = div_done ? quo_next : alu_data;
  assign push_flag = div_done ? (rem_next != '0) : alu_flag;
  assign push_op   = div_done ? OP_DIV : op_sel;

  assign out_valid = !fifo_empty;

  mop_result_fifo #(
    .DATA_W    (DATA_W),
    .OUT_DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .push_flag (push_flag),
    .push_op   (push_op),
    .pop       (out_valid && out_ready),
    .head_data (out_data),
    .head_flag (out_flag),
    .head_op   (out_op),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_multi_op_pipe_processor.sv
// Scoreboard bench: commands push arithmetic-model results into a queue,
// a monitor compares the FIFO head against the queue front every valid cycle.
module tb_multi_op_pipe_processor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] op_sel = 2'b00;
  logic [7:0] a_in = 8'h00;
  logic [7:0] b_in = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_flag;
  logic [1:0] out_op;

  multi_op_pipe_processor #(.DATA_W(8), .OUT_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sel    (op_sel),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flag  (out_flag),
    .out_op    (out_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       f;
    logic [1:0] op;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   pops = 0;
  bit   mon_en = 1'b0;
  int   ready_mode = 1;

  function automatic exp_t model(int op, int a, int b);
    exp_t e;
    int   x;
    int   f;
    case (op)
      0: begin x = a + b; f = (x > 255) ? 1 : 0; end
      1: begin x = a - b + 256; f = (a < b) ? 1 : 0; end
      2: begin x = a * b; f = (x > 255) ? 1 : 0; end
      default: begin x = a / (b + 1); f = ((a % (b + 1)) != 0) ? 1 : 0; end
    endcase
    e.d  = 8'(x % 256);
    e.f  = (f != 0);
    e.op = 2'(op);
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Consumer: out_ready changes at negedge+1, well clear of the rising edge.
  always @(negedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (mon_en && !rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'({out_op, out_flag, out_data}), 32'hFFFF_FFFF);
      end else begin
        e = exp_q[0];
        $display("head op=%0d data=%02h flag=%0b exp op=%0d data=%02h flag=%0b pop=%0b",
                 out_op, out_data, out_flag, e.op, e.d, e.f, out_ready);
        chk("head", 32'({out_op, out_flag, out_data}), 32'({e.op, e.f, e.d}));
        if (out_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  task automatic send(int op, int a, int b, int max_wait, output bit ok);
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    op_sel   = 2'(op);
    a_in     = 8'(a);
    b_in     = 8'(b);
    ok = 1'b0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      if (in_ready) begin
        exp_q.push_back(model(op, a, b));
        ok = 1'b1;
        @(posedge clk);
      end else begin
        @(negedge clk);
        #1;
      end
    end
    #1;
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(int max_wait);
    for (int i = 0; i < max_wait && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    #3;
    chk("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit ok;
    int seen;

    // Reset behaviour
    @(negedge clk); #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_outs", 32'({out_valid, out_op, out_flag, out_data}), 32'd0);
    mon_en = 1'b1;

    // Directed ALU cases, first one with latency check
    send(0, 8'hF0, 8'h20, 20, ok);
    @(negedge clk); #3;
    chk("add_latency_valid", 32'(out_valid), 32'd1);
    send(1, 8'h05, 8'h07, 20, ok);
    send(1, 8'h07, 8'h05, 20, ok);
    send(2, 8'h10, 8'h10, 20, ok);
    send(2, 8'h0F, 8'h11, 20, ok);
    drain(50);

    // DIV latency: busy for exactly 8 cycles after acceptance
    send(3, 200, 9, 20, ok);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #3;
      chk("div_busy_in_ready", 32'(in_ready), 32'd0);
      chk("div_busy_out_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk); #3;
    chk("div_done_out_valid", 32'(out_valid), 32'd1);
    send(3, 8'hFF, 8'hFF, 20, ok);
    drain(50);

    // Backpressure: four fill the FIFO, the fifth waits for a pop
    ready_mode = 0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) send(0, k + 1, 8'h10, 20, ok);
    @(negedge clk); #1;
    in_valid = 1'b1;
    op_sel   = 2'b00;
    a_in     = 8'h55;
    b_in     = 8'h01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #3;
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_occupancy", 32'(exp_q.size()), 32'd4);
    end
    @(posedge clk); #2;
    ready_mode = 1;
    send(0, 8'h55, 8'h01, 30, ok);
    chk("fifth_after_pop", 32'(pops >= 1), 32'd1);
    drain(50);

    // Reset in the middle of a divide
    send(3, 8'hC8, 8'h03, 20, ok);
    @(negedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_mid_div_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("after_abort_in_ready", 32'(in_ready), 32'd1);
    chk("after_abort_out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #3;
      if (out_valid) seen++;
    end
    chk("aborted_div_silent", 32'(seen), 32'd0);
    send(0, 8'h01, 8'h01, 20, ok);
    drain(50);

    // Randomised traffic with random consumer stalls
    ready_mode = 2;
    for (int k = 0; k < 60; k++) begin
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), 200, ok);
    end
    @(posedge clk); #2;
    ready_mode = 1;
    drain(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
